// File: rtl/multicycle_control_if.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control_if
//  Description : Bus between the LEGv8 multi-cycle control FSM and the
//                datapath / memories. It carries the instruction opcode,
//                the memory ready handshakes, the control strobes and the
//                status outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
interface multicycle_control_if #(
  parameter int OPCODE_W  = 11,
  parameter int ALUOP_W   = 2,
  parameter int RETIRED_W = 32
);
  // Datapath / memory side inputs to the controller
  logic [OPCODE_W-1:0]  opcode;
  logic                 imem_ready;
  logic                 dmem_ready;

  // Controller outputs
  logic                 imem_req;
  logic                 ir_write;
  logic                 pc_write;
  logic                 reg2_loc;
  logic                 uncondbranch;
  logic                 branch;
  logic                 branch_nz;
  logic                 mem_read;
  logic                 mem_write;
  logic                 mem_to_reg;
  logic [ALUOP_W-1:0]   alu_op;
  logic                 alu_src;
  logic                 reg_write;
  logic                 illegal;
  logic [RETIRED_W-1:0] retired;

  // Controller view
  modport master (
    input  opcode, imem_ready, dmem_ready,
    output imem_req, ir_write, pc_write, reg2_loc, uncondbranch, branch,
           branch_nz, mem_read, mem_write, mem_to_reg, alu_op, alu_src,
           reg_write, illegal, retired
  );

  // Datapath / memory view
  modport slave (
    output opcode, imem_ready, dmem_ready,
    input  imem_req, ir_write, pc_write, reg2_loc, uncondbranch, branch,
           branch_nz, mem_read, mem_write, mem_to_reg, alu_op, alu_src,
           reg_write, illegal, retired
  );
endinterface
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control
//  Description : Multi-cycle LEGv8 control FSM. Sequences every instruction
//                through FETCH / DECODE / EXECUTE / MEM / WB with ready
//                handshakes to instruction and data memory, decodes the
//                R-type, ADDI/SUBI, LDUR/STUR, CBZ/CBNZ and B groups, traps
//                on illegal opcodes and counts retired instructions.
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control #(
  parameter int OPCODE_W   = 11,
  parameter int ALUOP_W    = 2,
  parameter int RETIRED_W  = 32,
  parameter int ENABLE_IMM = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  multicycle_control_if.master   bus
);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_TRAP    = 3'd5
  } state_t;

  // Instruction group of the latched opcode
  typedef enum logic [2:0] {
    K_RTYPE   = 3'd0,
    K_ITYPE   = 3'd1,
    K_LDUR    = 3'd2,
    K_STUR    = 3'd3,
    K_CBZ     = 3'd4,
    K_CBNZ    = 3'd5,
    K_B       = 3'd6,
    K_ILLEGAL = 3'd7
  } kind_t;

  state_t                state;
  state_t                state_next;
  kind_t                 kind;
  logic [OPCODE_W-1:0]   ir;
  logic                  illegal_q;
  logic [RETIRED_W-1:0]  retired_q;

  // Sequencing strobes
  logic                  imem_req;
  logic                  ir_write;
  logic                  pc_write;
  logic                  reg_write;
  logic                  mem_read;
  logic                  mem_write;
  logic                  retire;

  // Static decode outputs
  logic                  reg2_loc;
  logic                  uncondbranch;
  logic                  branch;
  logic                  branch_nz;
  logic                  mem_to_reg;
  logic [ALUOP_W-1:0]    alu_op;
  logic                  alu_src;
  logic                  in_instr;

  // Classify the latched opcode; ADDI/SUBI are legal only when enabled
  always_comb begin
    kind = K_ILLEGAL;
    casez (ir)
      11'b10001011000,
      11'b11001011000,
      11'b10001010000,
      11'b10101010000: kind = K_RTYPE;
      11'b1001000100?,
      11'b1101000100?: kind = (ENABLE_IMM != 0) ? K_ITYPE : K_ILLEGAL;
      11'b11111000010: kind = K_LDUR;
      11'b11111000000: kind = K_STUR;
      11'b10110100???: kind = K_CBZ;
      11'b10110101???: kind = K_CBNZ;
      11'b000101?????: kind = K_B;
      default:         kind = K_ILLEGAL;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and sequencing strobes
  always_comb begin
    state_next = state;
    imem_req   = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    retire     = 1'b0;
    case (state)
      S_FETCH: begin
        imem_req = 1'b1;
        if (bus.imem_ready) begin
          ir_write   = 1'b1;
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        state_next = (kind == K_ILLEGAL) ? S_TRAP : S_EXECUTE;
      end
      S_EXECUTE: begin
        case (kind)
          K_CBZ, K_CBNZ, K_B: begin
            // The datapath decides taken/not-taken; the PC is always updated
            pc_write   = 1'b1;
            retire     = 1'b1;
            state_next = S_FETCH;
          end
          K_LDUR, K_STUR: state_next = S_MEM;
          default:        state_next = S_WB;
        endcase
      end
      S_MEM: begin
        mem_read  = (kind == K_LDUR);
        mem_write = (kind == K_STUR);
        if (bus.dmem_ready) begin
          if (kind == K_LDUR) begin
            state_next = S_WB;
          end else begin
            pc_write   = 1'b1;
            retire     = 1'b1;
            state_next = S_FETCH;
          end
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        pc_write   = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_TRAP: begin
        state_next = S_TRAP;
      end
      default: begin
        state_next = S_FETCH;
      end
    endcase
  end

  // Static decode outputs, held from DECODE until the instruction retires
  always_comb begin
    in_instr     = (state == S_DECODE) || (state == S_EXECUTE) ||
                   (state == S_MEM)    || (state == S_WB);
    reg2_loc     = 1'b0;
    uncondbranch = 1'b0;
    branch       = 1'b0;
    branch_nz    = 1'b0;
    mem_to_reg   = 1'b0;
    alu_op       = '0;
    alu_src      = 1'b0;
    if (in_instr) begin
      case (kind)
        K_RTYPE: begin
          alu_op = ALUOP_W'(2'b10);
        end
        K_ITYPE: begin
          alu_op  = ALUOP_W'(2'b11);
          alu_src = 1'b1;
        end
        K_LDUR: begin
          alu_src    = 1'b1;
          mem_to_reg = 1'b1;
        end
        K_STUR: begin
          alu_src  = 1'b1;
          reg2_loc = 1'b1;
        end
        K_CBZ: begin
          alu_op   = ALUOP_W'(2'b01);
          reg2_loc = 1'b1;
          branch   = 1'b1;
        end
        K_CBNZ: begin
          alu_op    = ALUOP_W'(2'b01);
          reg2_loc  = 1'b1;
          branch    = 1'b1;
          branch_nz = 1'b1;
        end
        K_B: begin
          uncondbranch = 1'b1;
        end
        default: begin
          alu_op = '0;
        end
      endcase
    end
  end

  // Instruction register: captures the opcode on the accepted fetch
  always_ff @(posedge clk) begin
    if (reset) begin
      ir <= '0;
    end else if (ir_write) begin
      ir <= bus.opcode;
    end
  end

  // Sticky trap flag, set as the FSM leaves DECODE for TRAP
  always_ff @(posedge clk) begin
    if (reset) begin
      illegal_q <= 1'b0;
    end else if ((state == S_DECODE) && (kind == K_ILLEGAL)) begin
      illegal_q <= 1'b1;
    end
  end

  // Retired-instruction counter, bumped with the final pc_write; wraps freely
  always_ff @(posedge clk) begin
    if (reset) begin
      retired_q <= '0;
    end else if (retire) begin
      retired_q <= retired_q + RETIRED_W'(1);
    end
  end

  assign bus.imem_req     = imem_req;
  assign bus.ir_write     = ir_write;
  assign bus.pc_write     = pc_write;
  assign bus.reg2_loc     = reg2_loc;
  assign bus.uncondbranch = uncondbranch;
  assign bus.branch       = branch;
  assign bus.branch_nz    = branch_nz;
  assign bus.mem_read     = mem_read;
  assign bus.mem_write    = mem_write;
  assign bus.mem_to_reg   = mem_to_reg;
  assign bus.alu_op       = alu_op;
  assign bus.alu_src      = alu_src;
  assign bus.reg_write    = reg_write;
  assign bus.illegal      = illegal_q;
  assign bus.retired      = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_control
//  Description : Self-checking bench for multicycle_control. Two instances:
//                dut0 with ADDI/SUBI enabled, dut1 with them disabled.
//                Expected behaviour comes from an instruction-level model
//                (class, latency, strobe counts, decode fields).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;

  localparam int CL_R = 0, CL_I = 1, CL_LD = 2, CL_ST = 3,
                 CL_CBZ = 4, CL_CBNZ = 5, CL_B = 6, CL_BAD = 7;
  localparam logic [14:0] OUT_IDLE = 15'b100_0000_0000_0000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  int   model_retired = 0;

  always #5 clk = ~clk;

  multicycle_control_if #(.OPCODE_W(11), .ALUOP_W(2), .RETIRED_W(32)) bus0();
  multicycle_control_if #(.OPCODE_W(11), .ALUOP_W(2), .RETIRED_W(32)) bus1();

  multicycle_control #(.OPCODE_W(11), .ALUOP_W(2), .RETIRED_W(32), .ENABLE_IMM(1))
    dut0 (.clk(clk), .reset(reset), .bus(bus0));
  multicycle_control #(.OPCODE_W(11), .ALUOP_W(2), .RETIRED_W(32), .ENABLE_IMM(0))
    dut1 (.clk(clk), .reset(reset), .bus(bus1));

  // One comparison point
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Instruction class from the opcode patterns of the decode table
  function automatic int classify(input logic [10:0] op, input bit imm_on);
    if (op == 11'b10001011000 || op == 11'b11001011000 ||
        op == 11'b10001010000 || op == 11'b10101010000) return CL_R;
    if (op[10:1] == 10'b1001000100 || op[10:1] == 10'b1101000100)
      return imm_on ? CL_I : CL_BAD;
    if (op == 11'b11111000010) return CL_LD;
    if (op == 11'b11111000000) return CL_ST;
    if (op[10:3] == 8'b10110100) return CL_CBZ;
    if (op[10:3] == 8'b10110101) return CL_CBNZ;
    if (op[10:5] == 6'b000101) return CL_B;
    return CL_BAD;
  endfunction

  // Expected {reg2_loc, alu_src, alu_op, branch, branch_nz, uncondbranch, mem_to_reg}
  function automatic logic [7:0] statics(input int cl);
    case (cl)
      CL_R:    return 8'b0_0_10_0_0_0_0;
      CL_I:    return 8'b0_1_11_0_0_0_0;
      CL_LD:   return 8'b0_1_00_0_0_0_1;
      CL_ST:   return 8'b1_1_00_0_0_0_0;
      CL_CBZ:  return 8'b1_0_01_1_0_0_0;
      CL_CBNZ: return 8'b1_0_01_1_1_0_0;
      CL_B:    return 8'b0_0_00_0_0_1_0;
      default: return 8'b0;
    endcase
  endfunction

  // Random opcode of a given class, don't-care bits randomised
  function automatic logic [10:0] make_op(input int cl);
    logic [10:0] rt [4];
    rt = '{11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000};
    case (cl)
      CL_R:    return rt[$urandom_range(0, 3)];
      CL_I:    return {($urandom_range(0, 1) != 0) ? 10'b1101000100 : 10'b1001000100,
                       1'($urandom)};
      CL_LD:   return 11'b11111000010;
      CL_ST:   return 11'b11111000000;
      CL_CBZ:  return {8'b10110100, 3'($urandom)};
      CL_CBNZ: return {8'b10110101, 3'($urandom)};
      default: return {6'b000101, 5'($urandom)};
    endcase
  endfunction

  function automatic int latency(input int cl, input int iwait, input int dwait);
    case (cl)
      CL_CBZ, CL_CBNZ, CL_B: return iwait + 3;
      CL_LD:                 return iwait + 5 + dwait;
      CL_ST:                 return iwait + 4 + dwait;
      default:               return iwait + 4;
    endcase
  endfunction

  function automatic logic [14:0] outs0();
    return {bus0.imem_req, bus0.ir_write, bus0.pc_write, bus0.reg_write,
            bus0.reg2_loc, bus0.uncondbranch, bus0.branch, bus0.branch_nz,
            bus0.mem_read, bus0.mem_write, bus0.mem_to_reg, bus0.alu_src,
            bus0.alu_op, bus0.illegal};
  endfunction

  // Run one legal instruction on dut0 starting in FETCH
  task automatic run_instr(input logic [10:0] op, input int iwait, input int dwait,
                           input string name);
    int cl;
    int lat;
    int k;
    int n_ir, n_req, n_pc, n_rw, n_rwpc, n_mr, n_mw;
    bit done;
    logic [7:0] st;
    cl  = classify(op, 1'b1);
    st  = statics(cl);
    lat = latency(cl, iwait, dwait);
    k = 0; done = 1'b0;
    n_ir = 0; n_req = 0; n_pc = 0; n_rw = 0; n_rwpc = 0; n_mr = 0; n_mw = 0;
    while (!done && k < 40) begin
      bus0.opcode     = (k == iwait) ? op : 11'($urandom);
      bus0.imem_ready = (k < iwait) ? 1'b0 : (k == iwait) ? 1'b1 : 1'($urandom);
      bus0.dmem_ready = (k < iwait + 3) ? 1'($urandom) :
                        (k < iwait + 3 + dwait) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (k == 0) begin
        chk({name, " retired"}, 64'(bus0.retired), 64'(32'(model_retired)));
        chk({name, " illegal"}, 64'(bus0.illegal), 64'(0));
      end
      chk($sformatf("%s decode k=%0d", name, k),
          64'({bus0.reg2_loc, bus0.alu_src, bus0.alu_op, bus0.branch,
               bus0.branch_nz, bus0.uncondbranch, bus0.mem_to_reg}),
          64'((k <= iwait) ? 8'h00 : st));
      n_ir   += int'(bus0.ir_write);
      n_req  += int'(bus0.imem_req);
      n_pc   += int'(bus0.pc_write);
      n_rw   += int'(bus0.reg_write);
      n_rwpc += int'(bus0.reg_write && bus0.pc_write);
      n_mr   += int'(bus0.mem_read);
      n_mw   += int'(bus0.mem_write);
      if (bus0.pc_write) done = 1'b1;
      @(posedge clk); #1;
      k++;
    end
    chk({name, " cycles"},    64'(k),      64'(lat));
    chk({name, " ir_write"},  64'(n_ir),   64'(1));
    chk({name, " imem_req"},  64'(n_req),  64'(iwait + 1));
    chk({name, " pc_write"},  64'(n_pc),   64'(1));
    chk({name, " reg_write"}, 64'(n_rw),
        64'((cl == CL_R || cl == CL_I || cl == CL_LD) ? 1 : 0));
    chk({name, " rw_final"},  64'(n_rwpc), 64'(n_rw));
    chk({name, " mem_read"},  64'(n_mr),   64'((cl == CL_LD) ? dwait + 1 : 0));
    chk({name, " mem_write"}, 64'(n_mw),   64'((cl == CL_ST) ? dwait + 1 : 0));
    model_retired++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n_rw;
    int n_pc;
    bus0.opcode = '0; bus0.imem_ready = 1'b0; bus0.dmem_ready = 1'b0;
    bus1.opcode = '0; bus1.imem_ready = 1'b0; bus1.dmem_ready = 1'b0;

    // Reset and idle state
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset outputs", 64'(outs0()), 64'(OUT_IDLE));
    chk("reset retired", 64'(bus0.retired), 64'(0));
    @(posedge clk); #1;

    // Directed sequence
    run_instr(11'b10001011000, 0, 0, "ADD");
    run_instr(11'b11111000010, 0, 2, "LDUR_wait2");
    run_instr(11'b11111000000, 0, 0, "STUR");
    run_instr(11'b10110101011, 0, 0, "CBNZ");
    run_instr(11'b00010100110, 0, 0, "B");
    run_instr(11'b10010001000, 0, 0, "ADDI");
    run_instr(11'b10110100000, 2, 0, "CBZ_iwait2");

    // Random instruction mix with random memory wait states
    for (int i = 0; i < 60; i++) begin
      int cl;
      cl = $urandom_range(0, 6);
      run_instr(make_op(cl), $urandom_range(0, 3), $urandom_range(0, 3),
                $sformatf("rnd%0d", i));
    end
    bus0.imem_ready = 1'b0;
    @(negedge clk);
    chk("retired after mix", 64'(bus0.retired), 64'(32'(model_retired)));
    @(posedge clk); #1;

    // Illegal opcode: trap, sticky, no fetch or writes
    bus0.opcode = 11'b00000000000; bus0.imem_ready = 1'b1;
    @(negedge clk);
    chk("trap fetch ir_write", 64'(bus0.ir_write), 64'(1));
    for (int k = 1; k < 14; k++) begin
      @(posedge clk); #1;
      bus0.opcode = 11'($urandom); bus0.imem_ready = 1'($urandom);
      bus0.dmem_ready = 1'($urandom);
      @(negedge clk);
      chk($sformatf("trap k=%0d", k),
          64'({bus0.illegal, bus0.imem_req, bus0.ir_write, bus0.pc_write, bus0.reg_write}),
          64'((k == 1) ? 5'b00000 : 5'b10000));
      if (k >= 2)
        chk($sformatf("trap decode k=%0d", k), 64'(outs0()), 64'(15'd1));
    end
    chk("trap retired", 64'(bus0.retired), 64'(32'(model_retired)));

    // Reset leaves the trap
    @(posedge clk); #1 reset = 1'b1; bus0.imem_ready = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("post-trap reset outputs", 64'(outs0()), 64'(OUT_IDLE));
    chk("post-trap reset retired", 64'(bus0.retired), 64'(0));
    model_retired = 0;
    @(posedge clk); #1;
    run_instr(11'b10101010000, 1, 0, "ORR_after_trap");

    // Reset during MEM of an LDUR aborts it
    n_rw = 0; n_pc = 0;
    bus0.opcode = 11'b11111000010; bus0.imem_ready = 1'b1; bus0.dmem_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_rw += int'(bus0.reg_write);
      n_pc += int'(bus0.pc_write);
      if (k < 3) begin
        @(posedge clk); #1;
        bus0.imem_ready = 1'($urandom); bus0.opcode = 11'($urandom);
      end
    end
    chk("abort in MEM mem_read", 64'(bus0.mem_read), 64'(1));
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0; bus0.imem_ready = 1'b0; bus0.dmem_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("abort idle k=%0d", k), 64'(outs0()), 64'(OUT_IDLE));
      n_rw += int'(bus0.reg_write);
      n_pc += int'(bus0.pc_write);
      @(posedge clk); #1;
    end
    chk("abort retired", 64'(bus0.retired), 64'(0));
    chk("abort reg_write", 64'(n_rw), 64'(0));
    chk("abort pc_write", 64'(n_pc), 64'(0));

    // ADDI with immediates disabled traps on dut1
    bus1.opcode = 11'b10010001000; bus1.imem_ready = 1'b1;
    @(negedge clk);
    chk("noimm ir_write", 64'(bus1.ir_write), 64'(1));
    for (int k = 1; k < 12; k++) begin
      @(posedge clk); #1;
      bus1.opcode = 11'($urandom); bus1.imem_ready = 1'($urandom);
      bus1.dmem_ready = 1'($urandom);
      @(negedge clk);
      chk($sformatf("noimm k=%0d", k),
          64'({bus1.illegal, bus1.imem_req, bus1.pc_write, bus1.reg_write, bus1.alu_src}),
          64'((k == 1) ? 5'b00000 : 5'b10000));
    end
    chk("noimm retired", 64'(bus1.retired), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
